// File: rtl/iobus_pkg.sv
// Shared types and MMIO address map for the IOBUS arbiter and its peripherals.
package iobus_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam logic [31:0] SWITCHES_AD = 32'h11000000;
    localparam logic [31:0] LEDS_AD     = 32'h11080000;
    localparam logic [31:0] SSEG_AD     = 32'h110C0000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the master that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ~last;
        end else if (req[1]) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-master round-robin arbiter for the shared MMIO IOBUS with a bounded tenure.
module iobus_arbiter
    import iobus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        M0_REQ,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    input  logic        M0_WR,
    output logic        M0_GNT,
    output logic [31:0] M0_RDATA,
    input  logic        M1_REQ,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    input  logic        M1_WR,
    output logic        M1_GNT,
    output logic [31:0] M1_RDATA,
    output logic [31:0] IOBUS_ADDR,
    output logic [31:0] IOBUS_OUT,
    output logic        IOBUS_WR,
    input  logic [31:0] IOBUS_IN,
    output logic        BUSY
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             last_q, last_d;

    logic owner, own_req, oth_req, win;

    rr_pick2 u_pick (
        .req  ({M1_REQ, M0_REQ}),
        .last (last_q),
        .win  (win)
    );

    assign owner   = (state_q == OWN1);
    assign own_req = owner ? M1_REQ : M0_REQ;
    assign oth_req = owner ? M0_REQ : M1_REQ;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    state_d = win ? OWN1 : OWN0;
                    hcnt_d  = CNT_ONE;
                    last_d  = win;
                end
            end
            OWN0, OWN1: begin
                // Release and forced hand-off share one path; hand-off only if the other asks.
                if (!own_req || (oth_req && hcnt_q == HOLD_LIM)) begin
                    if (oth_req) begin
                        state_d = owner ? OWN0 : OWN1;
                        hcnt_d  = CNT_ONE;
                        last_d  = ~owner;
                    end else begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end
                end else if (hcnt_q != HOLD_LIM) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        M0_GNT     = (state_q == OWN0);
        M1_GNT     = (state_q == OWN1);
        BUSY       = M0_GNT | M1_GNT;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        unique case (state_q)
            OWN0: begin
                IOBUS_ADDR = M0_ADDR;
                IOBUS_OUT  = M0_WDATA;
                IOBUS_WR   = M0_WR;
            end
            OWN1: begin
                IOBUS_ADDR = M1_ADDR;
                IOBUS_OUT  = M1_WDATA;
                IOBUS_WR   = M1_WR;
            end
            default: ;
        endcase
        M0_RDATA = M0_GNT ? IOBUS_IN : '0;
        M1_RDATA = M1_GNT ? IOBUS_IN : '0;
    end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Scoreboard bench: directed per-cycle vectors push the expected owner, a negedge monitor checks.
module tb_iobus_arbiter;
    import iobus_pkg::*;

    localparam int NONE = 0;
    localparam int G0   = 1;
    localparam int G1   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wr, m0_gnt, m1_req, m1_wr, m1_gnt;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] iobus_addr, iobus_out, iobus_in;
    logic        iobus_wr, busy;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        wr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    iobus_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .M0_REQ     (m0_req),
        .M0_ADDR    (m0_addr),
        .M0_WDATA   (m0_wdata),
        .M0_WR      (m0_wr),
        .M0_GNT     (m0_gnt),
        .M0_RDATA   (m0_rdata),
        .M1_REQ     (m1_req),
        .M1_ADDR    (m1_addr),
        .M1_WDATA   (m1_wdata),
        .M1_WR      (m1_wr),
        .M1_GNT     (m1_gnt),
        .M1_RDATA   (m1_rdata),
        .IOBUS_ADDR (iobus_addr),
        .IOBUS_OUT  (iobus_out),
        .IOBUS_WR   (iobus_wr),
        .IOBUS_IN   (iobus_in),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
            chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
            chk("iobus_addr", iobus_addr, e.addr);
            chk("iobus_out", iobus_out, e.wdat);
            chk("iobus_wr", 32'(iobus_wr), 32'(e.wr));
            chk("m0_rdata", m0_rdata, e.rd0);
            chk("m1_rdata", m1_rdata, e.rd1);
            chk("busy", 32'(busy), 32'(e.busy));
        end
    end

    // Drive requests for one cycle; eg is the hand-derived owner during this cycle.
    task automatic cyc(input logic r0, input logic r1, input int eg);
        exp_t e;
        m0_req = r0;
        m1_req = r1;
        e.g0   = (eg == G0);
        e.g1   = (eg == G1);
        e.addr = (eg == G0) ? m0_addr  : (eg == G1) ? m1_addr  : 32'h0;
        e.wdat = (eg == G0) ? m0_wdata : (eg == G1) ? m1_wdata : 32'h0;
        e.wr   = (eg == G0) ? m0_wr    : (eg == G1) ? m1_wr    : 1'b0;
        e.rd0  = (eg == G0) ? iobus_in : 32'h0;
        e.rd1  = (eg == G1) ? iobus_in : 32'h0;
        e.busy = (eg != NONE);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d", sb.size());
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        m0_addr  = SWITCHES_AD;
        m0_wdata = 32'hDEAD0001;
        m0_wr    = 1'b1;
        m1_addr  = LEDS_AD;
        m1_wdata = 32'h0000A5A5;
        m1_wr    = 1'b1;
        iobus_in = 32'h00001234;
        @(posedge clk);
        #1;

        // Reset held with M0 requesting a write: nothing reaches the bus.
        repeat (3) cyc(1, 0, NONE);
        rst_n = 1'b1;
        cyc(1, 0, NONE);
        cyc(1, 0, G0);
        m0_wr = 1'b0;
        cyc(0, 0, G0);
        m0_wr = 1'b1;
        cyc(0, 0, NONE);

        // Single master write from M1.
        cyc(0, 1, NONE);
        cyc(0, 1, G1);
        cyc(0, 0, G1);
        cyc(0, 0, NONE);

        // Tie out of reset goes to M0, then hand-off with no idle gap.
        rst_n = 1'b0;
        cyc(1, 1, NONE);
        rst_n = 1'b1;
        cyc(1, 1, NONE);
        repeat (3) cyc(1, 1, G0);
        cyc(0, 1, G0);
        cyc(0, 1, G1);
        cyc(0, 0, G1);
        cyc(0, 0, NONE);

        // Starvation bound: alternation every MAX_HOLD=4 cycles.
        iobus_in = 32'h5A5A0001;
        cyc(1, 1, NONE);
        for (int r = 0; r < 3; r++) begin
            repeat (4) cyc(1, 1, (r % 2 == 1) ? G1 : G0);
        end
        cyc(0, 0, G1);
        cyc(0, 0, NONE);

        // Lone owner saturates; a late request then forces an immediate hand-off.
        cyc(1, 0, NONE);
        repeat (6) cyc(1, 0, G0);
        cyc(1, 1, G0);
        cyc(1, 1, G1);
        cyc(1, 1, G1);

        // Reset mid-tenure (M1, HCNT=3): grant drops, then M0 wins the tie.
        rst_n = 1'b0;
        cyc(1, 1, G1);
        rst_n = 1'b1;
        cyc(1, 1, NONE);
        cyc(1, 1, G0);
        cyc(0, 0, G0);
        cyc(0, 0, NONE);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
